// File: rtl/seq_mult8x8.sv
// -----------------------------------------------------------------------------
// seq_mult8x8 -- sequential 8x8 unsigned multiplier
//
// Builds a 16-bit product from four 4x4 partial products computed one per
// clock by a single mult4x4 instance. The accumulated sum is copied to the
// output register only when the last partial product has been added.
//
// Parameters:
//   DONE_HOLD       1: done_flag stays high until the next accepted start
//                   0: done_flag is a one-cycle pulse
//
// Ports:
//   clk             in   1   system clock, rising edge
//   reset_a         in   1   asynchronous reset, active-high
//   start           in   1   request, sampled only while idle
//   dataa           in   8   multiplicand, unsigned
//   datab           in   8   multiplier, unsigned
//   product8x8_out  out  16  result of the last completed multiply
//   done_flag       out  1   result valid
//   busy            out  1   multiply in progress
//   dbg_state       out  3   (SEQ_MULT_DBG_EN only) IDLE=0, S0..S3=1..4
//   dbg_pp          out  8   (SEQ_MULT_DBG_EN only) current mult4x4 product
//
// Build option: define SEQ_MULT_DBG_EN to add the dbg_state/dbg_pp ports.
// -----------------------------------------------------------------------------

// 4x4 unsigned multiplier used as the partial-product engine.
module mult4x4 (
  input  logic [3:0] dataam,
  input  logic [3:0] databm,
  output logic [7:0] product
);
  assign product = {4'b0000, dataam} * {4'b0000, databm};
endmodule

module seq_mult8x8 #(
  parameter int DONE_HOLD = 1
) (
  input  logic        clk,
  input  logic        reset_a,
  input  logic        start,
  input  logic [7:0]  dataa,
  input  logic [7:0]  datab,
  output logic [15:0] product8x8_out,
  output logic        done_flag,
  output logic        busy
`ifdef SEQ_MULT_DBG_EN
  ,
  output logic [2:0]  dbg_state,
  output logic [7:0]  dbg_pp
`endif
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S0   = 3'd1,
    S1   = 3'd2,
    S2   = 3'd3,
    S3   = 3'd4
  } state_t;

  state_t      state, next_state;
  logic [7:0]  a_r, b_r;
  logic [15:0] acc;
  logic [3:0]  mult_a, mult_b;
  logic [7:0]  pp;
  logic [15:0] pp_ext;

  mult4x4 u_mult4x4 (
    .dataam  (mult_a),
    .databm  (mult_b),
    .product (pp)
  );

  assign pp_ext = {8'h00, pp};
  assign busy   = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) state <= IDLE;
    else         state <= next_state;
  end

  // NOTE: every output of this block gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    next_state = state;
    mult_a     = a_r[3:0];
    mult_b     = b_r[3:0];
    case (state)
      IDLE: if (start) next_state = S0;
      S0:   next_state = S1;
      S1: begin
        mult_a     = a_r[7:4];
        next_state = S2;
      end
      S2: begin
        mult_b     = b_r[7:4];
        next_state = S3;
      end
      S3: begin
        mult_a     = a_r[7:4];
        mult_b     = b_r[7:4];
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Operand latch, accumulator and result register. The cross terms
  // (S1, S2) both carry weight 16; the high-nibble term (S3) carries 256.
  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      a_r            <= 8'h00;
      b_r            <= 8'h00;
      acc            <= 16'h0000;
      product8x8_out <= 16'h0000;
      done_flag      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_r       <= dataa;
            b_r       <= datab;
            acc       <= 16'h0000;
            done_flag <= 1'b0;
          end else if (DONE_HOLD == 0) begin
            done_flag <= 1'b0;
          end
        end
        S0: acc <= pp_ext;
        S1: acc <= acc + (pp_ext << 4);
        S2: acc <= acc + (pp_ext << 4);
        S3: begin
          product8x8_out <= acc + (pp_ext << 8);
          done_flag      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SEQ_MULT_DBG_EN
  assign dbg_state = state;
  assign dbg_pp    = pp;
`endif

endmodule
